// File: rtl/ram_req_ctrl_if.sv
// Request/response handshake between a requester and ram_req_ctrl.
// master: requester side; slave: the controller.
interface ram_req_ctrl_if #(
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned DATAWIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDRWIDTH-1:0] req_addr;
  logic [DATAWIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request-side controller for a single-port RAM macro with a shared tri-state
// data bus. Turns valid/ready read/write requests into cs/we/oe/addr pin
// sequences and returns a one-cycle response pulse.
// Optional: define RAMREQ_STATS_EN to add saturating wr_count/rd_count outputs.
module ram_req_ctrl #(
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SIZE      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_req_ctrl_if.slave        bus,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [ADDRWIDTH-1:0] ram_addr,
  inout  wire  [DATAWIDTH-1:0] ram_data
`ifdef RAMREQ_STATS_EN
  ,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
`endif
);

  typedef enum logic [1:0] {StIdle, StWrite, StRdAddr, StRdData} state_e;

  state_e               state_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [DATAWIDTH-1:0] rsp_rdata_q;
  logic                 accept;
  logic                 in_range;

  assign bus.req_ready = (state_q == StIdle) & ~rst;
  assign accept        = bus.req_valid & bus.req_ready;
  assign in_range      = (32'(bus.req_addr) < SIZE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Only the WRITE state drives the bus; async reset returns to IDLE, so the
  // bus is released the moment rst rises.
  assign ram_data = (state_q == StWrite) ? wdata_q : {DATAWIDTH{1'bz}};

  // Controller FSM with registered RAM pin controls and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wdata_q     <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_addr    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef RAMREQ_STATS_EN
      wr_count    <= 16'h0000;
      rd_count    <= 16'h0000;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wdata_q <= bus.req_wdata;
            if (!in_range) begin
              // Rejected without touching the RAM; respond next cycle.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (bus.req_we) begin
              state_q  <= StWrite;
              ram_cs   <= 1'b1;
              ram_we   <= 1'b1;
              ram_oe   <= 1'b0;
              ram_addr <= bus.req_addr;
            end else begin
              state_q  <= StRdAddr;
              ram_cs   <= 1'b1;
              ram_we   <= 1'b0;
              ram_oe   <= 1'b0;
              ram_addr <= bus.req_addr;
            end
          end
        end
        StWrite: begin
          state_q     <= StIdle;
          ram_cs      <= 1'b0;
          ram_we      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
`ifdef RAMREQ_STATS_EN
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
`endif
        end
        StRdAddr: begin
          // RAM has latched the word; open its output driver.
          state_q <= StRdData;
          ram_oe  <= 1'b1;
        end
        StRdData: begin
          state_q     <= StIdle;
          ram_cs      <= 1'b0;
          ram_oe      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ram_data;
`ifdef RAMREQ_STATS_EN
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
